// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared opcodes, FSM states and ALU/mux encodings for the
//                multicycle MIPS control unit.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_j     = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTYPEEX, S_ALUWB, S_BRANCH, S_IMMEX, S_IMMWB, S_JUMP
    } state_t;

    typedef enum logic [2:0] {
        ALUOP_ADD   = 3'b000,
        ALUOP_SUB   = 3'b001,
        ALUOP_FUNCT = 3'b010,
        ALUOP_OR    = 3'b011,
        ALUOP_AND   = 3'b100
    } aluop_t;

    localparam logic [1:0] c_srcb_b      = 2'b00;
    localparam logic [1:0] c_srcb_four   = 2'b01;
    localparam logic [1:0] c_srcb_imm    = 2'b10;
    localparam logic [1:0] c_srcb_immsh  = 2'b11;

    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

    localparam logic [3:0] c_alu_and = 4'b0000;
    localparam logic [3:0] c_alu_or  = 4'b0001;
    localparam logic [3:0] c_alu_add = 4'b0010;
    localparam logic [3:0] c_alu_xor = 4'b0011;
    localparam logic [3:0] c_alu_sub = 4'b0110;
    localparam logic [3:0] c_alu_slt = 4'b0111;
    localparam logic [3:0] c_alu_sll = 4'b1000;
    localparam logic [3:0] c_alu_srl = 4'b1001;
    localparam logic [3:0] c_alu_sra = 4'b1010;
    localparam logic [3:0] c_alu_nor = 4'b1100;

endpackage
`default_nettype wire

// File: rtl/aludec.sv
`default_nettype none
// ============================================================================
//  Module      : aludec
//  Description : ALU decoder: maps aluop/funct to ALU control and shamt select.
//  Revision    : 1.0  initial release
// ============================================================================
module aludec
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    input  aluop_t     aluop,
    output logic [3:0] alucontrol,
    output logic       shiftreg
);

    always_comb begin
        alucontrol = c_alu_add;
        shiftreg   = 1'b0;
        case (aluop)
            ALUOP_SUB: alucontrol = c_alu_sub;
            ALUOP_OR:  alucontrol = c_alu_or;
            ALUOP_AND: alucontrol = c_alu_and;
            ALUOP_FUNCT: begin
                case (funct)
                    6'b100000: alucontrol = c_alu_add;
                    6'b100010: alucontrol = c_alu_sub;
                    6'b100100: alucontrol = c_alu_and;
                    6'b100101: alucontrol = c_alu_or;
                    6'b100110: alucontrol = c_alu_xor;
                    6'b100111: alucontrol = c_alu_nor;
                    6'b101010: alucontrol = c_alu_slt;
                    6'b000000: begin alucontrol = c_alu_sll; shiftreg = 1'b1; end
                    6'b000010: begin alucontrol = c_alu_srl; shiftreg = 1'b1; end
                    6'b000011: begin alucontrol = c_alu_sra; shiftreg = 1'b1; end
                    default:   alucontrol = c_alu_add;
                endcase
            end
            default: alucontrol = c_alu_add;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : mc_controller
//  Description : Moore FSM sequencing the shared-memory multicycle MIPS datapath.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_controller
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       zeroext,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic [3:0] alucontrol,
    output logic       shiftreg,
    output logic       illegal_op,
    output logic       mem_err
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_wait_cnt;
    aluop_t            w_aluop;
    logic              w_pcwrite;
    logic              w_branch;
    logic              w_ne;
    logic              w_mem_access;
    logic              w_timeout;

    // Memory access is a pure function of state, which keeps the timeout path free of loops.
    assign w_mem_access = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            assign w_timeout = w_mem_access & ~mem_ready &
                               (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    assign mem_err = w_timeout;
    assign pcen    = w_pcwrite | (w_branch & (zero ^ w_ne));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_mem_access && !mem_ready && !w_timeout)
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            else
                r_wait_cnt <= '0;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_aluop    = ALUOP_ADD;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_ne       = 1'b0;
        mem_req    = w_mem_access;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcsrc      = c_pcsrc_alu;
        alusrca    = 1'b0;
        alusrcb    = c_srcb_b;
        zeroext    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        illegal_op = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                alusrcb = c_srcb_four;
                if (mem_ready) begin
                    irwrite   = 1'b1;
                    w_pcwrite = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = c_srcb_immsh;
                case (op)
                    c_op_lw, c_op_sw:     w_next = S_MEMADR;
                    c_op_rtype:           w_next = S_RTYPEEX;
                    c_op_beq, c_op_bne:   w_next = S_BRANCH;
                    c_op_addi, c_op_ori:  w_next = S_IMMEX;
                    c_op_j:               w_next = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = c_srcb_imm;
                w_next  = (op == c_op_sw) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready)
                    w_next = S_MEMWB;
                else if (w_timeout)
                    w_next = S_FETCH;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = ~w_timeout;
                if (mem_ready || w_timeout)
                    w_next = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                w_aluop = ALUOP_FUNCT;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                w_aluop  = ALUOP_SUB;
                pcsrc    = c_pcsrc_aluout;
                w_branch = 1'b1;
                w_ne     = (op == c_op_bne);
                w_next   = S_FETCH;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = c_srcb_imm;
                if (op == c_op_ori) begin
                    w_aluop = ALUOP_OR;
                    zeroext = 1'b1;
                end
                w_next = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_JUMP: begin
                pcsrc     = c_pcsrc_jump;
                w_pcwrite = 1'b1;
                w_next    = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    aludec u_aludec (
        .funct      (funct),
        .aluop      (w_aluop),
        .alucontrol (alucontrol),
        .shiftreg   (shiftreg)
    );

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_controller
//  Description : Directed table plus randomized instruction-stream bench for mc_controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_controller;

    localparam int TO = 4;

    // Instruction steps as seen by the model (independent numbering).
    localparam int SI = 0, SF = 1, SD = 2, SMA = 3, SMR = 4, SMWB = 5, SMW = 6;
    localparam int SRX = 7, SAWB = 8, SBR = 9, SIX = 10, SIWB = 11, SJ = 12;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       mem_req, memwrite, iord, irwrite, pcen, alusrca, zeroext;
    logic       regdst, memtoreg, regwrite, shiftreg, illegal_op, mem_err;
    logic [1:0] pcsrc, alusrcb;
    logic [3:0] alucontrol;
    logic [20:0] act;
    logic [8:0]  act_key;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_controller #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite), .iord(iord),
        .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .zeroext(zeroext), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alucontrol(alucontrol), .shiftreg(shiftreg),
        .illegal_op(illegal_op), .mem_err(mem_err)
    );

    assign act = {mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
                  zeroext, regdst, memtoreg, regwrite, alucontrol, shiftreg,
                  illegal_op, mem_err};
    assign act_key = {mem_req, memwrite, irwrite, pcen, pcsrc, regwrite, illegal_op, mem_err};

    task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [4:0] ref_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return {4'b0010, 1'b0};
            6'b100010: return {4'b0110, 1'b0};
            6'b100100: return {4'b0000, 1'b0};
            6'b100101: return {4'b0001, 1'b0};
            6'b100110: return {4'b0011, 1'b0};
            6'b100111: return {4'b1100, 1'b0};
            6'b101010: return {4'b0111, 1'b0};
            6'b000000: return {4'b1000, 1'b1};
            6'b000010: return {4'b1001, 1'b1};
            6'b000011: return {4'b1010, 1'b1};
            default:   return {4'b0010, 1'b0};
        endcase
    endfunction

    function automatic logic [20:0] exp_out(input int st, input logic [5:0] o, input logic [5:0] fn,
                                            input logic z, input logic rdy, input int wt);
        logic req, mw, io, irw, pce, asa, zx, rd, m2r, rw, ill, err;
        logic [1:0] psrc, asb;
        logic [4:0] alu;
        {req, mw, io, irw, pce, asa, zx, rd, m2r, rw, ill} = '0;
        psrc = 2'b00; asb = 2'b00; alu = {4'b0010, 1'b0};
        err = (st == SF || st == SMR || st == SMW) && !rdy && (wt == TO - 1);
        case (st)
            SF:   begin req = 1; asb = 2'b01; irw = rdy; pce = rdy; end
            SD:   begin asb = 2'b11;
                        ill = !(o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                          6'b000101, 6'b001000, 6'b001101, 6'b000010}); end
            SMA:  begin asa = 1; asb = 2'b10; end
            SMR:  begin req = 1; io = 1; end
            SMWB: begin m2r = 1; rw = 1; end
            SMW:  begin req = 1; io = 1; mw = !err; end
            SRX:  begin asa = 1; alu = ref_alu(fn); end
            SAWB: begin rd = 1; rw = 1; end
            SBR:  begin asa = 1; alu = {4'b0110, 1'b0}; psrc = 2'b01;
                        pce = (o == 6'b000101) ? !z : z; end
            SIX:  begin asa = 1; asb = 2'b10;
                        if (o == 6'b001101) begin alu = {4'b0001, 1'b0}; zx = 1; end end
            SIWB: rw = 1;
            SJ:   begin psrc = 2'b10; pce = 1; end
            default: ;
        endcase
        return {req, mw, io, irw, pce, psrc, asa, asb, zx, rd, m2r, rw, alu, ill, err};
    endfunction

    // Holds reset 3 cycles checking the idle vector, releases at a falling edge.
    task automatic do_reset();
        reset_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            check("reset_idle", act, exp_out(SI, op, funct, zero, mem_ready, 0));
        end
        reset_n = 1'b1;
    endtask

    typedef struct packed {
        logic [5:0] op; logic z; logic rdy;
        logic req; logic mw; logic irw; logic pce; logic [1:0] psrc;
        logic rw; logic ill; logic err;
    } vec_t;

    vec_t tbl[35];
    int   q[$];
    int   wt, st, k;
    logic [5:0] cur_op, cur_fn;

    initial begin
        //          op         z  r  req mw irw pce psrc rw ill err
        tbl[0]  = '{6'b000000, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0};
        tbl[1]  = '{6'b000000, 0, 1, 1, 0, 1, 1, 2'b00, 0, 0, 0};
        tbl[2]  = '{6'b100011, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0};
        tbl[3]  = '{6'b100011, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0};
        tbl[4]  = '{6'b100011, 0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0};
        tbl[5]  = '{6'b100011, 0, 1, 0, 0, 0, 0, 2'b00, 1, 0, 0};
        tbl[6]  = '{6'b000000, 0, 1, 1, 0, 1, 1, 2'b00, 0, 0, 0};
        tbl[7]  = '{6'b000101, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0};
        tbl[8]  = '{6'b000101, 0, 1, 0, 0, 0, 1, 2'b01, 0, 0, 0};
        tbl[9]  = '{6'b000000, 0, 1, 1, 0, 1, 1, 2'b00, 0, 0, 0};
        tbl[10] = '{6'b000101, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0};
        tbl[11] = '{6'b000101, 1, 1, 0, 0, 0, 0, 2'b01, 0, 0, 0};
        tbl[12] = '{6'b000000, 0, 1, 1, 0, 1, 1, 2'b00, 0, 0, 0};
        tbl[13] = '{6'b000100, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0};
        tbl[14] = '{6'b000100, 1, 1, 0, 0, 0, 1, 2'b01, 0, 0, 0};
        tbl[15] = '{6'b000000, 0, 1, 1, 0, 1, 1, 2'b00, 0, 0, 0};
        tbl[16] = '{6'b000100, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0};
        tbl[17] = '{6'b000100, 0, 1, 0, 0, 0, 0, 2'b01, 0, 0, 0};
        tbl[18] = '{6'b000000, 0, 1, 1, 0, 1, 1, 2'b00, 0, 0, 0};
        tbl[19] = '{6'b111111, 0, 1, 0, 0, 0, 0, 2'b00, 0, 1, 0};
        tbl[20] = '{6'b000000, 0, 1, 1, 0, 1, 1, 2'b00, 0, 0, 0};
        tbl[21] = '{6'b101011, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0};
        tbl[22] = '{6'b101011, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0};
        tbl[23] = '{6'b101011, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0};
        tbl[24] = '{6'b101011, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0};
        tbl[25] = '{6'b101011, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0};
        tbl[26] = '{6'b101011, 0, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0};
        tbl[27] = '{6'b000000, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0};
        tbl[28] = '{6'b000000, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0};
        tbl[29] = '{6'b000000, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0};
        tbl[30] = '{6'b000000, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 1};
        tbl[31] = '{6'b000000, 0, 1, 1, 0, 1, 1, 2'b00, 0, 0, 0};
        tbl[32] = '{6'b000010, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0};
        tbl[33] = '{6'b000010, 0, 1, 0, 0, 0, 1, 2'b10, 0, 0, 0};
        tbl[34] = '{6'b000000, 0, 1, 1, 0, 1, 1, 2'b00, 0, 0, 0};

        // Directed sequence: lw, bne/beq both ways, illegal op, stalled sw, fetch timeout, j.
        do_reset();
        for (int i = 0; i < 35; i++) begin
            if (i > 0) @(negedge clk);
            op = tbl[i].op; zero = tbl[i].z; mem_ready = tbl[i].rdy; funct = '0;
            #1;
            check($sformatf("table[%0d]", i), {12'b0, act_key},
                  {12'b0, tbl[i].req, tbl[i].mw, tbl[i].irw, tbl[i].pce, tbl[i].psrc,
                   tbl[i].rw, tbl[i].ill, tbl[i].err});
        end

        // Reset asserted in the middle of a stalled store.
        do_reset();
        @(negedge clk); mem_ready = 1'b1; #1;
        check("mid_fetch", act, exp_out(SF, op, funct, zero, mem_ready, 0));
        @(negedge clk); op = 6'b101011;
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b0; #1;
        check("mid_memwr", act, exp_out(SMW, op, funct, zero, mem_ready, 0));
        #2 reset_n = 1'b0; #1;
        check("async_reset_idle", act, exp_out(SI, op, funct, zero, mem_ready, 0));
        @(negedge clk); reset_n = 1'b1; mem_ready = 1'b1; #1;
        check("post_reset_idle", act, exp_out(SI, op, funct, zero, mem_ready, 0));
        @(negedge clk); #1;
        check("post_reset_fetch", act, exp_out(SF, op, funct, zero, mem_ready, 0));

        // Randomized instruction stream against the step-sequence model.
        do_reset();
        q = {SI}; wt = 0; cur_op = '0; cur_fn = '0;
        for (int n = 0; n < 2500; n++) begin
            if (n > 0) @(negedge clk);
            if (q.size() == 0) begin
                k = $urandom_range(0, 8);
                case (k)
                    0: cur_op = 6'b000000;  1: cur_op = 6'b100011;  2: cur_op = 6'b101011;
                    3: cur_op = 6'b000100;  4: cur_op = 6'b000101;  5: cur_op = 6'b001000;
                    6: cur_op = 6'b001101;  7: cur_op = 6'b000010;
                    default: cur_op = 6'($urandom);
                endcase
                cur_fn = 6'($urandom);
                q.push_back(SF); q.push_back(SD);
                case (cur_op)
                    6'b000000:            begin q.push_back(SRX); q.push_back(SAWB); end
                    6'b100011:            begin q.push_back(SMA); q.push_back(SMR); q.push_back(SMWB); end
                    6'b101011:            begin q.push_back(SMA); q.push_back(SMW); end
                    6'b000100, 6'b000101: q.push_back(SBR);
                    6'b001000, 6'b001101: begin q.push_back(SIX); q.push_back(SIWB); end
                    6'b000010:            q.push_back(SJ);
                    default: ;
                endcase
            end
            st = q[0];
            op = cur_op; funct = cur_fn;
            zero = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 9) < 6);
            #1;
            check($sformatf("random[%0d] step %0d", n, st), act,
                  exp_out(st, op, funct, zero, mem_ready, wt));
            if ((st == SF || st == SMR || st == SMW) && !mem_ready) begin
                if (wt == TO - 1) begin
                    q.delete();
                    wt = 0;
                end else begin
                    wt++;
                end
            end else begin
                wt = 0;
                void'(q.pop_front());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
